// File: rtl/tt_sweep_ctrl_if.sv
// Sweep controller bus: controls, golden/captured tables and function-under-test I/O.
// Pure wiring; no latency and no backpressure (start/abort are level-sampled each edge).
interface tt_sweep_ctrl_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
) ();
    localparam int NCOMB = 1 << N_IN;
    localparam int TW    = N_OUT * NCOMB;

    logic             start;
    logic             abort;
    logic [TW-1:0]    expected;
    logic [N_IN-1:0]  vec;
    logic [N_OUT-1:0] f;
    logic             busy;
    logic             done;
    logic [TW-1:0]    table_out;
    logic [NCOMB-1:0] mismatch;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_fail;

    modport master (
        output start, abort, expected, f,
        input  vec, busy, done, table_out, mismatch, err_count, first_fail
    );

    modport slave (
        input  start, abort, expected, f,
        output vec, busy, done, table_out, mismatch, err_count, first_fail
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweeper: steps vec through all 2^N_IN codes, SETTLE+1 cycles each, and checks f against a golden table.
// Sweep takes 2^N_IN*(SETTLE+1) cycles then a one-cycle done; no backpressure, abort cancels on the next edge.
module tt_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    tt_sweep_ctrl_if.slave bus
);
    localparam int NCOMB = 1 << N_IN;
    localparam int TW    = N_OUT * NCOMB;
    localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NCOMB - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [TW-1:0]    exp_q, exp_d;
    logic [TW-1:0]    table_q, table_d;
    logic [NCOMB-1:0] mism_q, mism_d;
    logic [N_IN:0]    err_q, err_d;
    logic [N_IN-1:0]  ff_q, ff_d;
    logic             busy, done;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_SETTLE;
            S_SETTLE: begin
                if (bus.abort)             state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (bus.abort)              state_d = S_IDLE;
                else if (vec_q == VEC_LAST) state_d = S_DONE;
                else                        state_d = S_SETTLE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        exp_d   = exp_q;
        table_d = table_q;
        mism_d  = mism_q;
        err_d   = err_q;
        ff_d    = ff_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.expected;
                    table_d = '0;
                    mism_d  = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    vec_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    vec_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                // abort wins over the capture on the same edge
                if (bus.abort) begin
                    vec_d = '0;
                    cnt_d = '0;
                end else begin
                    table_d[vec_q*N_OUT +: N_OUT] = bus.f;
                    if (bus.f != exp_q[vec_q*N_OUT +: N_OUT]) begin
                        mism_d[vec_q] = 1'b1;
                        err_d         = err_q + 1'b1;
                        if (err_q == '0) ff_d = vec_q;
                    end
                    if (vec_q != VEC_LAST) vec_d = vec_q + 1'b1;
                    cnt_d = '0;
                end
            end
            S_DONE:  vec_d = '0;
            default: vec_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            vec_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            mism_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign bus.vec        = vec_q;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.table_out  = table_q;
    assign bus.mismatch   = mism_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: drives the 3-input majority/parity function and scoreboards each sweep's results.
module tb_tt_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_ctrl_if #(.N_IN(3), .N_OUT(2)) dif ();
    tt_sweep_ctrl_if #(.N_IN(3), .N_OUT(2)) dif1 ();

    tt_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(2)) u_dut  (.clk(clk), .rst(rst), .bus(dif.slave));
    tt_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(dif1.slave));

    // F1 = x^y^z, F2 = maj(x,y,z); vec bit 2 = x
    function automatic logic [1:0] fut(input logic [2:0] v);
        return {(v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]), ^v};
    endfunction

    assign dif.f  = fut(dif.vec);
    assign dif1.f = fut(dif1.vec);

    typedef struct packed {
        logic [15:0] tab;
        logic [7:0]  mis;
        logic [3:0]  err;
        logic [2:0]  ff;
    } res_t;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        res_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_table"},      dif.table_out,  e.tab);
            chk({tag, "_mismatch"},   dif.mismatch,   e.mis);
            chk({tag, "_err_count"},  dif.err_count,  e.err);
            chk({tag, "_first_fail"}, dif.first_fail, e.ff);
        end
    endtask

    task automatic sweep(input string tag, input logic [15:0] exp_tab, input res_t want,
                         input int abort_vec, input bit disturb, input bit both_ctl);
        int edge_n;
        int busy_n;
        bit vec_ok;
        bit seen_done;
        dif.expected = exp_tab;
        dif.start    = 1'b1;
        dif.abort    = both_ctl;
        sb_q.push_back(want);
        tick();
        dif.start = 1'b0;
        dif.abort = 1'b0;
        edge_n = 0;
        busy_n = 0;
        vec_ok = 1'b1;
        while (!dif.done && edge_n < 100) begin
            if (dif.busy) busy_n++;
            if (dif.vec !== 3'(edge_n / 3)) vec_ok = 1'b0;
            if (abort_vec >= 0 && dif.busy && dif.vec == abort_vec) begin
                dif.abort = 1'b1;
                tick();
                dif.abort = 1'b0;
                chk({tag, "_busy_after_abort"}, dif.busy, 0);
                chk({tag, "_vec_after_abort"},  dif.vec,  0);
                seen_done = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    if (dif.done) seen_done = 1'b1;
                    tick();
                end
                chk({tag, "_no_done"}, seen_done, 0);
                sb_check(tag);
                return;
            end
            if (disturb && edge_n == 4) dif.start = 1'b1;
            if (disturb && edge_n == 5) begin
                dif.start    = 1'b0;
                dif.expected = ~exp_tab;
            end
            tick();
            edge_n++;
        end
        chk({tag, "_done_edge"},    edge_n, 24);
        chk({tag, "_busy_cycles"},  busy_n, 24);
        chk({tag, "_vec_sequence"}, vec_ok, 1);
        chk({tag, "_busy_in_done"}, dif.busy, 0);
        sb_check(tag);
        dif.start = disturb;
        tick();
        dif.start = 1'b0;
        chk({tag, "_done_one_cycle"}, dif.done, 0);
        chk({tag, "_idle_after"},     dif.busy, 0);
        chk({tag, "_vec_back"},       dif.vec,  0);
    endtask

    initial begin
        int guard;
        int edge_n;
        dif.start     = 1'b0;
        dif.abort     = 1'b0;
        dif.expected  = '0;
        dif1.start    = 1'b0;
        dif1.abort    = 1'b0;
        dif1.expected = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            chk("idle_busy", dif.busy, 0);
            chk("idle_done", dif.done, 0);
        end
        chk("rst_vec",        dif.vec,        0);
        chk("rst_table",      dif.table_out,  0);
        chk("rst_mismatch",   dif.mismatch,   0);
        chk("rst_err_count",  dif.err_count,  0);
        chk("rst_first_fail", dif.first_fail, 0);

        sweep("pass",        16'hE994, '{16'hE994, 8'h00, 4'd0, 3'd0}, -1, 1'b0, 1'b0);
        sweep("fault_e0_e5", 16'hE196, '{16'hE994, 8'h21, 4'd2, 3'd0}, -1, 1'b0, 1'b0);
        sweep("fault_e9d6",  16'hE9D6, '{16'hE994, 8'h09, 4'd2, 3'd0}, -1, 1'b0, 1'b0);
        sweep("last_index",  16'h2994, '{16'hE994, 8'h80, 4'd1, 3'd7}, -1, 1'b0, 1'b0);
        sweep("all_wrong",   16'h166B, '{16'hE994, 8'hFF, 4'd8, 3'd0}, -1, 1'b0, 1'b0);
        sweep("abort",       16'hE196, '{16'h0014, 8'h01, 4'd1, 3'd0},  3, 1'b0, 1'b0);
        sweep("ignored",     16'hE994, '{16'hE994, 8'h00, 4'd0, 3'd0}, -1, 1'b1, 1'b0);
        sweep("start_abort", 16'h2994, '{16'hE994, 8'h80, 4'd1, 3'd7}, -1, 1'b0, 1'b1);

        dif.expected = 16'h166B;
        dif.start    = 1'b1;
        tick();
        dif.start = 1'b0;
        guard = 0;
        while (dif.vec != 3'd5 && guard < 100) begin
            tick();
            guard++;
        end
        chk("rst_mid_reach_vec5", guard < 100, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_vec",        dif.vec,        0);
        chk("rst_mid_busy",       dif.busy,       0);
        chk("rst_mid_done",       dif.done,       0);
        chk("rst_mid_table",      dif.table_out,  0);
        chk("rst_mid_mismatch",   dif.mismatch,   0);
        chk("rst_mid_err_count",  dif.err_count,  0);
        chk("rst_mid_first_fail", dif.first_fail, 0);

        dif1.expected = 16'hE196;
        dif1.start    = 1'b1;
        tick();
        dif1.start = 1'b0;
        edge_n = 0;
        while (!dif1.done && edge_n < 100) begin
            tick();
            edge_n++;
        end
        chk("s1_done_edge",  edge_n,          16);
        chk("s1_table",      dif1.table_out,  16'hE994);
        chk("s1_mismatch",   dif1.mismatch,   8'h21);
        chk("s1_err_count",  dif1.err_count,  2);
        chk("s1_first_fail", dif1.first_fail, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
